// File: rtl/hs4_sink_fifo.sv
// rtl/hs4_sink_fifo.sv - clocked sink for the 4-word 4-phase bundled-data channel with FWFT FIFO
//
// Purpose:
//   Active side of a 4-phase bundled-data channel. It raises req only when a
//   FIFO slot is free. It waits for the synchronized ack and captures the four
//   data words in that cycle. It then completes the return-to-zero phase.
//   Captured bundles are buffered in a first-word-fall-through FIFO and
//   presented on a valid/ready stream.
//
// Ports:
//   clk                    clock, rising-edge
//   rst                    asynchronous active-high reset
//   req                    4-phase request to upstream (registered)
//   ack                    4-phase acknowledge from upstream (asynchronous)
//   data_in0..data_in3     bundled data words, stable while ack is high
//   out_valid              FIFO head entry available
//   out_ready              downstream accepts the head entry
//   out_data0..out_data3   words of the FIFO head entry
//   count                  number of occupied FIFO entries
//   hs_state               handshake FSM state: 0 IDLE, 1 REQ, 2 RELEASE

module hs4_sink_fifo #(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     req,
  input  logic                     ack,
  input  logic [DWIDTH-1:0]        data_in0,
  input  logic [DWIDTH-1:0]        data_in1,
  input  logic [DWIDTH-1:0]        data_in2,
  input  logic [DWIDTH-1:0]        data_in3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        out_data0,
  output logic [DWIDTH-1:0]        out_data1,
  output logic [DWIDTH-1:0]        out_data2,
  output logic [DWIDTH-1:0]        out_data3,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               hs_state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  // ack synchronizer and its post-reset warm-up marker
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   w_ack_s;
  logic                   w_sync_ready;

  // handshake FSM
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   r_req;
  logic                   w_req_nxt;

  // FIFO
  logic [4*DWIDTH-1:0]    r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_has_slot;

  assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
  assign w_sync_ready = r_warm[SYNC_STAGES-1];
  assign w_has_slot   = (r_count < C_FULL);

  // Synchronizer flops reset to 0, so right after reset ack_s reads 0 even
  // if upstream still holds ack high. r_warm marks when the chain holds real
  // samples, so a stale ack cannot start a new transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_sync <= '0;
      r_warm     <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
      r_warm     <= {r_warm[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // FSM: state register (req registered alongside so it is glitch-free)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        // Reserving the slot here keeps the later capture from overflowing.
        if (w_sync_ready && !w_ack_s && w_has_slot) w_state_nxt = S_REQ;
        else                                        w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (w_ack_s) w_state_nxt = S_REL;
        else         w_state_nxt = S_REQ;
      end
      S_REL: begin
        if (!w_ack_s) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_REL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_req_nxt = (w_state_nxt == S_REQ);
    w_push    = (r_state == S_REQ) && w_ack_s;
  end

  assign w_pop = out_valid && out_ready;

  // Storage needs no reset; entries are only read once count says valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {data_in3, data_in2, data_in1, data_in0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign req       = r_req;
  assign hs_state  = r_state;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign {out_data3, out_data2, out_data1, out_data0} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_hs4_sink_fifo.sv
// tb/tb_hs4_sink_fifo.sv - directed and random-delay bench for hs4_sink_fifo
module tb_hs4_sink_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req;
  logic          ack = 1'b0;
  logic [DW-1:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [2:0]    count;
  logic [1:0]    hs_state;

  hs4_sink_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .count     (count),
    .hs_state  (hs_state)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream consumer and scoreboard
  logic [31:0] exp_q[$];
  int rdy_mode  = 0;   // 0 low, 1 high, 2 random
  int n_pops    = 0;
  int max_count = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(count) > max_count) max_count = int'(count);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) check("pop_unexpected", 64'(exp_q.size()), 64'd1);
        else check("pop_data", {out_data3, out_data2, out_data1, out_data0}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_req(input logic val, input string tag);
    int k = 0;
    while (req !== val && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, req, val);
  endtask

  // Upstream passivator model
  task automatic handshake(input logic [31:0] w, input int d_up, input int d_dn);
    wait_req(1'b1, "hs_req_rise");
    repeat (d_up) @(negedge clk);
    {data_in3, data_in2, data_in1, data_in0} = w;
    ack = 1'b1;
    exp_q.push_back(w);
    wait_req(1'b0, "hs_req_fall");
    repeat (d_dn) @(negedge clk);
    ack = 1'b0;
    {data_in3, data_in2, data_in1, data_in0} = ~w;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_state", hs_state, 2'd0);
    check("rst_count", count, 3'd0);
    check("rst_valid", out_valid, 1'b0);
    rst = 1'b0;

    // Test 1: single bundle, latency and return to IDLE
    rdy_mode = 1;
    n_pops   = 0;
    wait_req(1'b1, "t1_req");
    check("t1_state_req", hs_state, 2'd1);
    repeat (2) @(negedge clk);
    {data_in3, data_in2, data_in1, data_in0} = 32'h44332211;
    ack = 1'b1;
    exp_q.push_back(32'h44332211);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_data", {out_data3, out_data2, out_data1, out_data0}, 32'h44332211);
    wait_req(1'b0, "t1_req_fall");
    repeat (2) @(negedge clk);
    ack = 1'b0;
    lat = 0;
    while (hs_state != 2'd0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_idle", hs_state, 2'd0);
    check("t1_pops", 64'(n_pops), 64'd1);
    check("t1_count", count, 3'd0);

    // Test 2: full FIFO stalls upstream, then 5th bundle after draining
    rdy_mode = 0;
    n_pops   = 0;
    for (int i = 0; i < 4; i++) handshake(32'hA0B0C0D0 + 32'(i), 2, 2);
    repeat (10) @(negedge clk);
    check("t2_count_full", count, 3'd4);
    check("t2_req_stall", req, 1'b0);
    check("t2_state_idle", hs_state, 2'd0);
    rdy_mode = 1;
    handshake(32'hA0B0C0D4, 1, 1);
    drain(100);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t2_pops", 64'(n_pops), 64'd5);

    // Test 3: continuous streaming, pointers wrap twice
    n_pops    = 0;
    max_count = 0;
    for (int i = 0; i < 8; i++) handshake({4{8'(8'h10 + i)}} ^ 32'h00FF00FF, 0, 0);
    drain(100);
    check("t3_pops", 64'(n_pops), 64'd8);
    check("t3_maxcount", 64'(max_count), 64'd1);

    // Test 4: reset mid-handshake with ack high
    rdy_mode = 0;
    handshake(32'hA5A55A5A, 1, 1);
    wait_req(1'b1, "t4_req");
    check("t4_state_req", hs_state, 2'd1);
    check("t4_count_pre", count, 3'd1);
    {data_in3, data_in2, data_in1, data_in0} = 32'hDEADBEEF;
    ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t4_async_req", req, 1'b0);
    check("t4_async_count", count, 3'd0);
    check("t4_async_state", hs_state, 2'd0);
    check("t4_async_valid", out_valid, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_hold_req", req, 1'b0);
    check("t4_hold_count", count, 3'd0);
    check("t4_hold_state", hs_state, 2'd0);
    ack = 1'b0;
    lat = 0;
    while (!req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t4_rearm_lat", 64'(lat), 64'd3);
    check("t4_no_capture", count, 3'd0);

    // Test 5: random ready and random upstream delays
    rdy_mode  = 2;
    n_pops    = 0;
    max_count = 0;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      handshake(w, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    drain(2000);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t5_pops", 64'(n_pops), 64'd100);
    check("t5_max_le_depth", 64'(max_count <= DEPTH), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
